// File: rtl/rcb_pkg.sv
// Shared types and limits for the RAM control block.
package rcb_pkg;

  typedef enum logic {
    RCB_ARB_RD_PRI = 1'b0,
    RCB_ARB_WR_PRI = 1'b1
  } rcb_arb_mode_e;

  localparam int RCB_MAX_RD = 4;

endpackage

// File: rtl/rcb_wq.sv
// Host write queue: in-order FIFO of {addr, data, be} entries with a
// per-read-channel address match against every occupied slot.
module rcb_wq
  import rcb_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int RAM_WIDTH = 64,
  parameter int DEPTH     = 4,
  parameter int NUM_RD    = 2,
  localparam int BE_W     = RAM_WIDTH / 8,
  localparam int PW       = $clog2(DEPTH),
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic [RAM_WIDTH-1:0]           push_data,
  input  logic [BE_W-1:0]                push_be,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              head_addr,
  output logic [RAM_WIDTH-1:0]           head_data,
  output logic [BE_W-1:0]                head_be,
  output logic                           full,
  output logic                           empty,
  output logic [LW-1:0]                  level,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  cmp_addr,
  output logic [NUM_RD-1:0]              match
);

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [RAM_WIDTH-1:0] data;
    logic [BE_W-1:0]      be;
  } wr_entry_t;

  wr_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [PW-1:0]    wr_ptr, rd_ptr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign {head_addr, head_data, head_be} = mem[rd_ptr];

  // Pointers, occupancy bits and level; push is never issued while full
  // and pop never while empty, so the two never touch the same slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        occ[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        occ[rd_ptr] <= 1'b0;
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Entry payload storage, not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_addr, push_data, push_be};
  end

  // A read channel matches if any occupied entry targets its address.
  always_comb begin
    match = '0;
    for (int r = 0; r < NUM_RD; r++)
      for (int e = 0; e < DEPTH; e++)
        if (occ[e] && (mem[e].addr == cmp_addr[r])) match[r] = 1'b1;
  end

endmodule

// File: rtl/rcb_mport.sv
// Multi-port RAM control block: NUM_RD round-robin read channels share one
// single-ported RAM with a queued host write stream. Writes are forced
// ahead of reads on write priority, starvation timeout or address hazard.
module rcb_mport
  import rcb_pkg::*;
#(
  parameter int RAM_WIDTH  = 64,
  parameter int ADDR_W     = 14,
  parameter int NUM_RD     = 2,
  parameter int WQ_DEPTH   = 4,
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 16,
  localparam int BE_W      = RAM_WIDTH / 8,
  localparam int LW        = $clog2(WQ_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_RD-1:0]                 rd_req,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD-1:0]                 rd_gnt,
  output logic [NUM_RD-1:0]                 rd_vld,
  output logic [NUM_RD-1:0][RAM_WIDTH-1:0]  rd_data,
  input  logic                              hpb_wr_vld,
  output logic                              hpb_wr_rdy,
  input  logic [ADDR_W-1:0]                 hpb_wr_addr,
  input  logic [RAM_WIDTH-1:0]              hpb_wr_data,
  input  logic [BE_W-1:0]                   hpb_wr_en,
  output logic                              rcb_wr_done,
  output logic [LW-1:0]                     wq_level
);

  localparam int CW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam rcb_arb_mode_e MODE = rcb_arb_mode_e'(ARB_MODE[0]);

  if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH < 8) begin : g_bad_width
    $error("rcb_mport: RAM_WIDTH must be a non-zero multiple of 8");
  end
  if (NUM_RD < 1 || NUM_RD > RCB_MAX_RD) begin : g_bad_rd
    $error("rcb_mport: NUM_RD out of range 1..4");
  end
  if (WQ_DEPTH < 2 || (WQ_DEPTH & (WQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rcb_mport: WQ_DEPTH must be a power of 2, >= 2");
  end
  if (ARB_MODE < 0 || ARB_MODE > 1) begin : g_bad_mode
    $error("rcb_mport: ARB_MODE must be 0 or 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("rcb_mport: STARVE_MAX must be >= 1");
  end

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [RAM_WIDTH-1:0] data;
    logic [BE_W-1:0]      be;
  } wr_entry_t;

  wr_entry_t                       head;
  logic                            push, pop, full, empty, hazard, force_wr, read_go;
  logic [NUM_RD-1:0]               match, elig, gnt_rr;
  logic [CW-1:0]                   rr_ptr, gch;
  logic [SW-1:0]                   starve;
  logic [RAM_WIDTH-1:0]            rd_q;
  logic [NUM_RD-1:0][RAM_WIDTH-1:0] hold;
  logic [RAM_WIDTH-1:0]            ram [2**ADDR_W];

  rcb_wq #(
    .ADDR_W(ADDR_W), .RAM_WIDTH(RAM_WIDTH), .DEPTH(WQ_DEPTH), .NUM_RD(NUM_RD)
  ) u_wq (
    .clk(clk), .reset_n(reset_n),
    .push(push), .push_addr(hpb_wr_addr), .push_data(hpb_wr_data), .push_be(hpb_wr_en),
    .pop(pop), .head_addr(head.addr), .head_data(head.data), .head_be(head.be),
    .full(full), .empty(empty), .level(wq_level),
    .cmp_addr(rd_addr), .match(match)
  );

  // A read hitting a queued address waits and pulls the queue forward, so
  // it never observes data older than a pending write.
  assign hpb_wr_rdy = !full;
  assign push       = hpb_wr_vld && !full;
  assign elig       = rd_req & ~match;
  assign hazard     = |(rd_req & match);
  assign force_wr   = !empty && ((MODE == RCB_ARB_WR_PRI) || (starve == SW'(STARVE_MAX)) || hazard);
  assign read_go    = !force_wr && (|elig);
  assign pop        = force_wr || (!read_go && !empty);
  assign rd_gnt     = read_go ? gnt_rr : '0;

  // Round-robin pick: lowest offset from rr_ptr among eligible channels.
  always_comb begin
    gnt_rr = '0;
    gch    = '0;
    for (int k = NUM_RD - 1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NUM_RD]) gch = CW'((int'(rr_ptr) + k) % NUM_RD);
    gnt_rr[gch] = |elig;
  end

  // Search start moves past the last granted channel; starve counter ages
  // the queue head while reads keep winning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      starve <= '0;
    end else begin
      if (read_go) rr_ptr <= (gch == CW'(NUM_RD - 1)) ? '0 : gch + 1'b1;
      if (empty || pop)                   starve <= '0;
      else if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
    end
  end

  // Single RAM port: one read or one byte-masked write per cycle.
  always_ff @(posedge clk) begin
    if (read_go) rd_q <= ram[rd_addr[gch]];
    if (pop)
      for (int b = 0; b < BE_W; b++)
        if (head.be[b]) ram[head.addr][b*8 +: 8] <= head.data[b*8 +: 8];
  end

  // Valid/done strobes and per-channel capture of the last returned word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld      <= '0;
      rcb_wr_done <= 1'b0;
      hold        <= '0;
    end else begin
      rd_vld      <= rd_gnt;
      rcb_wr_done <= pop;
      for (int c = 0; c < NUM_RD; c++)
        if (rd_vld[c]) hold[c] <= rd_q;
    end
  end

  // Granted channel sees fresh RAM output; others keep their last word.
  always_comb begin
    rd_data = hold;
    for (int c = 0; c < NUM_RD; c++)
      if (rd_vld[c]) rd_data[c] = rd_q;
  end

endmodule

// File: tb/tb_rcb_mport.sv
// Bench for rcb_mport: directed scenarios plus a randomized run, all
// checked against a transaction-level queue/array reference model.
module tb_rcb_mport;
  localparam int NRD = 2, AW = 14, DW = 64, BW = 8, QD = 4, SMAX = 16, LW = 3;

  logic                      clk = 1'b0, reset_n = 1'b0;
  logic [NRD-1:0]            rd_req = '0, rd_gnt, rd_vld;
  logic [NRD-1:0][AW-1:0]    rd_addr = '0;
  logic [NRD-1:0][DW-1:0]    rd_data;
  logic                      hpb_wr_vld = 1'b0, hpb_wr_rdy, rcb_wr_done;
  logic [AW-1:0]             hpb_wr_addr = '0;
  logic [DW-1:0]             hpb_wr_data = '0;
  logic [BW-1:0]             hpb_wr_en = '0;
  logic [LW-1:0]             wq_level;

  rcb_mport #(.RAM_WIDTH(DW), .ADDR_W(AW), .NUM_RD(NRD), .WQ_DEPTH(QD),
              .ARB_MODE(0), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .hpb_wr_vld(hpb_wr_vld), .hpb_wr_rdy(hpb_wr_rdy), .hpb_wr_addr(hpb_wr_addr),
    .hpb_wr_data(hpb_wr_data), .hpb_wr_en(hpb_wr_en),
    .rcb_wr_done(rcb_wr_done), .wq_level(wq_level));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } went_t;

  int checks = 0, failures = 0;
  logic [AW-1:0] pool [8] = '{14'h010, 14'h200, 14'h011, 14'h022, 14'h033, 14'h044, 14'h055, 14'h066};

  // reference model state
  went_t                  mq [$];
  logic [DW-1:0]          mram [int];
  int                     rr, starve, e_ch, e_level;
  bit                     e_commit, e_rdy, e_done;
  logic [NRD-1:0]         e_gnt, e_vld, o_gnt;
  logic                   o_rdy;
  logic [NRD-1:0][DW-1:0] e_data;

  task automatic model_reset();
    mq.delete(); rr = 0; starve = 0; e_vld = '0; e_data = '0; e_done = 0; e_level = 0;
  endtask

  // Decide this cycle's RAM operation from the arbitration rules.
  task automatic model_eval();
    logic [NRD-1:0] haz, elig;
    bit frc;
    haz = '0;
    for (int c = 0; c < NRD; c++)
      if (rd_req[c]) foreach (mq[i]) if (mq[i].addr == rd_addr[c]) haz[c] = 1'b1;
    frc  = (mq.size() > 0) && (starve >= SMAX || haz != '0);
    elig = rd_req & ~haz;
    e_gnt = '0; e_commit = 0; e_ch = -1;
    if (frc) e_commit = 1;
    else if (elig != '0) begin
      for (int k = 0; k < NRD; k++) if (e_ch < 0 && elig[(rr + k) % NRD]) e_ch = (rr + k) % NRD;
      e_gnt[e_ch] = 1'b1;
    end else if (mq.size() > 0) e_commit = 1;
    e_rdy = (mq.size() < QD);
  endtask

  task automatic model_advance();
    went_t h;
    bit was_empty;
    logic [DW-1:0] w;
    was_empty = (mq.size() == 0);
    e_vld = '0;
    if (e_ch >= 0) begin
      e_vld[e_ch] = 1'b1;
      e_data[e_ch] = mram[int'(rd_addr[e_ch])];
      rr = (e_ch + 1) % NRD;
    end
    if (e_commit) begin
      h = mq.pop_front();
      w = mram.exists(int'(h.addr)) ? mram[int'(h.addr)] : '0;
      for (int b = 0; b < BW; b++) if (h.be[b]) w[b*8 +: 8] = h.data[b*8 +: 8];
      mram[int'(h.addr)] = w;
    end
    starve = (was_empty || e_commit) ? 0 : starve + 1;
    if (hpb_wr_vld && e_rdy) mq.push_back({hpb_wr_addr, hpb_wr_data, hpb_wr_en});
    e_done = e_commit;
    e_level = mq.size();
  endtask

  // One clock: inputs already driven at the negedge; ends at next negedge.
  task automatic tick();
    model_eval();
    #1;
    o_gnt = rd_gnt;
    o_rdy = hpb_wr_rdy;
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    hpb_wr_addr = a; hpb_wr_data = d; hpb_wr_en = be;
  endtask

  task automatic drain();
    int n = 0;
    rd_req = '0; hpb_wr_vld = 1'b0;
    while (e_level != 0 && n < 40) begin tick(); n++; end
    tick();
    checks++;
    if (wq_level !== '0 || e_level != 0) begin
      failures++; $display("FAIL drain: level=%0d after %0d cycles, want 0", wq_level, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (hpb_wr_rdy !== 1'b1 || wq_level !== '0 || rcb_wr_done !== 1'b0 || rd_vld !== '0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b level=%0d done=%b vld=%b data=%h want 1/0/0/0/0",
               hpb_wr_rdy, wq_level, rcb_wr_done, rd_vld, rd_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    for (int i = 0; i < 8; i++) begin
      set_wr(pool[i], {$urandom, $urandom}, 8'hFF); hpb_wr_vld = 1'b1;
      tick();
      checks++;
      if (o_rdy !== 1'b1) begin failures++; $display("FAIL init_rdy: got %b want 1", o_rdy); end
    end
    drain();
  endtask

  task automatic test_idle_write();
    set_wr(pool[0], 64'h1122334455667788, 8'hFF); hpb_wr_vld = 1'b1;
    tick(); hpb_wr_vld = 1'b0;
    checks++;
    if (rcb_wr_done !== 1'b0) begin failures++; $display("FAIL idle_done_early: got %b want 0", rcb_wr_done); end
    tick();
    checks++;
    if (rcb_wr_done !== 1'b1) begin failures++; $display("FAIL idle_done: got %b want 1", rcb_wr_done); end
    rd_req = 2'b01; rd_addr[0] = pool[0];
    tick(); rd_req = '0;
    checks++;
    if (o_gnt !== 2'b01) begin failures++; $display("FAIL idle_rd_gnt: got %b want 01", o_gnt); end
    checks++;
    if (rd_vld !== 2'b01 || rd_data[0] !== 64'h1122334455667788) begin
      failures++; $display("FAIL idle_rd_data: vld=%b data=%h want 01/1122334455667788", rd_vld, rd_data[0]);
    end
    tick();
    checks++;
    if (rd_vld !== 2'b00 || rd_data[0] !== 64'h1122334455667788) begin
      failures++; $display("FAIL idle_rd_hold: vld=%b data=%h want 00/1122334455667788", rd_vld, rd_data[0]);
    end
  endtask

  task automatic test_byte_en();
    set_wr(pool[0], {8{8'h55}}, 8'hFF); hpb_wr_vld = 1'b1; tick();
    drain();
    set_wr(pool[0], {8{8'hAA}}, 8'h0F); hpb_wr_vld = 1'b1; tick();
    drain();
    rd_req = 2'b01; rd_addr[0] = pool[0];
    tick(); rd_req = '0;
    checks++;
    if (rd_vld[0] !== 1'b1 || rd_data[0] !== 64'h55555555AAAAAAAA) begin
      failures++; $display("FAIL byte_en: vld=%b data=%h want 1/55555555aaaaaaaa", rd_vld[0], rd_data[0]);
    end
    set_wr(pool[0], {8{8'h77}}, 8'h00); hpb_wr_vld = 1'b1; tick(); hpb_wr_vld = 1'b0;
    tick();
    checks++;
    if (rcb_wr_done !== 1'b1) begin failures++; $display("FAIL be_zero_done: got %b want 1", rcb_wr_done); end
    rd_req = 2'b01; tick(); rd_req = '0;
    checks++;
    if (rd_data[0] !== 64'h55555555AAAAAAAA) begin
      failures++; $display("FAIL be_zero_data: got %h want 55555555aaaaaaaa", rd_data[0]);
    end
    drain();
  endtask

  task automatic test_starve();
    int cc;
    bit seen;
    logic [NRD-1:0] last;
    rd_req = 2'b11; rd_addr[0] = pool[2]; rd_addr[1] = pool[3];
    set_wr(pool[4], {$urandom, $urandom}, 8'hFF); hpb_wr_vld = 1'b1;
    tick(); hpb_wr_vld = 1'b0; last = o_gnt;
    cc = 0; seen = 0;
    while (!seen && cc < 40) begin
      tick(); cc++;
      checks++;
      if (o_gnt !== e_gnt) begin failures++; $display("FAIL starve_gnt: cyc %0d got %b want %b", cc, o_gnt, e_gnt); end
      if (rcb_wr_done === 1'b1) seen = 1;
      else begin
        checks++;
        if (o_gnt !== ~last) begin failures++; $display("FAIL starve_alt: cyc %0d got %b want %b", cc, o_gnt, ~last); end
        last = o_gnt;
      end
    end
    checks++;
    if (!seen || cc != 17) begin failures++; $display("FAIL starve_commit: seen=%0d cycle=%0d want 1/17", seen, cc); end
    drain();
  endtask

  task automatic test_hazard();
    int cc;
    bit got;
    logic [DW-1:0] db;
    db = {$urandom, $urandom};
    rd_req = 2'b01; rd_addr[0] = pool[2];
    set_wr(pool[0], {$urandom, $urandom}, 8'hFF); hpb_wr_vld = 1'b1; tick();
    set_wr(pool[1], db, 8'hFF); tick();
    hpb_wr_vld = 1'b0; rd_req = 2'b10; rd_addr[1] = pool[1];
    cc = 0; got = 0;
    while (!got && cc < 10) begin
      tick(); cc++;
      checks++;
      if (o_gnt !== e_gnt) begin failures++; $display("FAIL hazard_gnt: cyc %0d got %b want %b", cc, o_gnt, e_gnt); end
      if (o_gnt[1]) got = 1;
    end
    rd_req = '0;
    checks++;
    if (!got || cc != 3) begin failures++; $display("FAIL hazard_wait: granted=%0d cycle=%0d want 1/3", got, cc); end
    checks++;
    if (rd_vld !== 2'b10 || rd_data[1] !== db) begin
      failures++; $display("FAIL hazard_data: vld=%b data=%h want 10/%h", rd_vld, rd_data[1], db);
    end
    drain();
  endtask

  task automatic test_full();
    int cc = 0, n = 0;
    rd_req = 2'b11; rd_addr[0] = pool[2]; rd_addr[1] = pool[3];
    set_wr(pool[4], {$urandom, $urandom}, 8'hFF); hpb_wr_vld = 1'b1;
    while (n < 5 && cc < 60) begin
      tick(); cc++;
      checks++;
      if (o_rdy !== e_rdy || wq_level !== LW'(e_level)) begin
        failures++; $display("FAIL full_track: cyc %0d rdy=%b level=%0d want %b/%0d", cc, o_rdy, wq_level, e_rdy, e_level);
      end
      if (cc == 5) begin
        checks++;
        if (o_rdy !== 1'b0 || wq_level !== 3'd4) begin
          failures++; $display("FAIL full_state: rdy=%b level=%0d want 0/4", o_rdy, wq_level);
        end
      end
      if (e_rdy) begin
        n++;
        if (n < 5) set_wr(pool[4 + (n % 4)], {$urandom, $urandom}, 8'hFF);
        else hpb_wr_vld = 1'b0;
      end
    end
    checks++;
    if (n != 5 || cc != 19 || wq_level !== 3'd4) begin
      failures++; $display("FAIL full_fifth: accepted=%0d at cycle %0d level=%0d want 5/19/4", n, cc, wq_level);
    end
    drain();
  endtask

  task automatic test_random();
    logic [NRD-1:0] pend = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < NRD; c++)
        if (!pend[c] && $urandom_range(0, 99) < 60) begin
          pend[c] = 1'b1; rd_addr[c] = pool[$urandom_range(0, 7)];
        end
      rd_req = pend;
      if (!hpb_wr_vld && $urandom_range(0, 99) < 40) begin
        set_wr(pool[$urandom_range(0, 7)], {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        hpb_wr_vld = 1'b1;
      end
      tick();
      checks++;
      if (o_gnt !== e_gnt || o_rdy !== e_rdy) begin
        failures++; $display("FAIL rand_comb: cyc %0d gnt=%b rdy=%b want %b/%b", cyc, o_gnt, o_rdy, e_gnt, e_rdy);
      end
      checks++;
      if (rd_vld !== e_vld || rd_data !== e_data) begin
        failures++; $display("FAIL rand_read: cyc %0d vld=%b data=%h want %b/%h", cyc, rd_vld, rd_data, e_vld, e_data);
      end
      checks++;
      if (rcb_wr_done !== e_done || wq_level !== LW'(e_level)) begin
        failures++; $display("FAIL rand_wr: cyc %0d done=%b level=%0d want %b/%0d", cyc, rcb_wr_done, wq_level, e_done, e_level);
      end
      pend = pend & ~e_gnt;
      if (hpb_wr_vld && e_rdy) hpb_wr_vld = 1'b0;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    rd_req = 2'b11; rd_addr[0] = pool[2]; rd_addr[1] = pool[3];
    for (int i = 0; i < 3; i++) begin
      set_wr(pool[5 + i], {$urandom, $urandom}, 8'hFF); hpb_wr_vld = 1'b1; tick();
    end
    hpb_wr_vld = 1'b0;
    checks++;
    if (wq_level !== 3'd3) begin failures++; $display("FAIL mid_level: got %0d want 3", wq_level); end
    reset_n = 1'b0; model_reset();
    #1;
    checks++;
    if (hpb_wr_rdy !== 1'b1 || wq_level !== '0 || rcb_wr_done !== 1'b0 || rd_vld !== '0) begin
      failures++; $display("FAIL mid_reset: rdy=%b level=%0d done=%b vld=%b want 1/0/0/00",
                           hpb_wr_rdy, wq_level, rcb_wr_done, rd_vld);
    end
    rd_req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if (rcb_wr_done !== 1'b0 || wq_level !== '0) begin
        failures++; $display("FAIL mid_after: done=%b level=%0d want 0/0", rcb_wr_done, wq_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_idle_write();
    test_byte_en();
    test_starve();
    test_hazard();
    test_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
